// File: rtl/ahb3lite_dma_read_slave.sv
// AHB-Lite bus types plus a read-only AHB-Lite slave that serves DMA reads from a
// 1-cycle-latency word memory, with wait states, burst-completion pulse and ERROR responses.
package ahb3lite_pkg;
  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } HBURST_Type;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_state;
endpackage

module ahb3lite_dma_read_slave
  import ahb3lite_pkg::*;
#(
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       MEM_DEPTH   = 1024,
  parameter int unsigned       WAIT_STATES = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  HBURST_Type                   HBURST,
  input  HTRANS_state                  HTRANS,
  input  logic                         HREADY,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADYOUT,
  output HRESP_state                   HRESP,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]            mem_rd_data,
  output logic                         slave_done
);

  localparam int unsigned       BYTES    = DATA_W / 8;
  localparam int unsigned       SIZE_LOG = $clog2(BYTES);
  localparam int unsigned       MA_W     = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0]   SPAN     = (ADDR_W + 1)'(MEM_DEPTH * BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt, wait_next;
  logic [4:0]        beat_cnt, beat_next, beat_inc;
  logic              first_q, first_next;
  logic              aborted_q, aborted_next;
  HBURST_Type        burst_q, burst_next;
  logic              done_next;
  logic              burst_last;
  logic [DATA_W-1:0] hold_q;

  logic              accept, valid, in_range, complete_okay;
  logic [ADDR_W-1:0] offset;

  assign accept   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign offset   = HADDR - BASE_ADDR;
  assign in_range = (HADDR >= BASE_ADDR) && ({1'b0, offset} < SPAN);
  assign valid    = !HWRITE && (HSIZE <= 3'(SIZE_LOG)) && in_range;

  assign mem_rd_en   = HRESETn && accept && valid;
  assign mem_rd_addr = offset[SIZE_LOG +: MA_W];

  assign complete_okay = (state == ST_DATA) && (wait_cnt == 4'd0);
  assign beat_inc      = beat_cnt + 5'd1;

  assign HREADYOUT = (state == ST_ERR1) ? 1'b0 :
                     (state == ST_DATA) ? (wait_cnt == 4'd0) : 1'b1;
  assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign HRDATA    = (state != ST_DATA) ? '0 : (first_q ? mem_rd_data : hold_q);

  // INCR ends when the master does not continue the burst; BUSY keeps it open.
  always_comb begin
    burst_last = 1'b0;
    case (burst_q)
      HBURST_SINGLE:              burst_last = 1'b1;
      HBURST_INCR:                burst_last = !HSEL || HTRANS == HTRANS_IDLE ||
                                               HTRANS == HTRANS_NONSEQ;
      HBURST_WRAP4, HBURST_INCR4: burst_last = (beat_inc == 5'd4);
      HBURST_WRAP8, HBURST_INCR8: burst_last = (beat_inc == 5'd8);
      default:                    burst_last = (beat_inc == 5'd16);
    endcase
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    state_next   = ST_IDLE;
    wait_next    = wait_cnt;
    beat_next    = beat_cnt;
    aborted_next = aborted_q;
    burst_next   = burst_q;
    first_next   = 1'b0;
    done_next    = 1'b0;

    case (state)
      ST_ERR1: state_next = ST_ERR2;
      ST_DATA: if (wait_cnt != 4'd0) begin
        state_next = ST_DATA;
        wait_next  = wait_cnt - 4'd1;
      end
      default: state_next = ST_IDLE;
    endcase

    if (complete_okay) begin
      beat_next = beat_inc;
      done_next = burst_last && !aborted_q;
    end

    // A new address phase overlaps the completing cycle of the previous beat.
    if (accept) begin
      burst_next   = HBURST;
      aborted_next = (HTRANS == HTRANS_NONSEQ) ? !valid : (aborted_q || !valid);
      if (HTRANS == HTRANS_NONSEQ || !valid) beat_next = 5'd0;
      if (valid) begin
        state_next = ST_DATA;
        wait_next  = 4'(WAIT_STATES);
        first_next = 1'b1;
      end else begin
        state_next = ST_ERR1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      wait_cnt   <= 4'd0;
      beat_cnt   <= 5'd0;
      first_q    <= 1'b0;
      aborted_q  <= 1'b0;
      burst_q    <= HBURST_SINGLE;
      slave_done <= 1'b0;
    end else begin
      state      <= state_next;
      wait_cnt   <= wait_next;
      beat_cnt   <= beat_next;
      first_q    <= first_next;
      aborted_q  <= aborted_next;
      burst_q    <= burst_next;
      slave_done <= done_next;
    end
  end

  // NOTE: the data holding register needs no reset; HRDATA is forced to 0 outside DATA.
  always_ff @(posedge HCLK) begin
    if (state == ST_DATA && first_q) hold_q <= mem_rd_data;
  end

endmodule

// File: tb/tb_ahb3lite_dma_read_slave.sv
// Directed self-checking bench: three slave configurations (32-bit zero-wait, 32-bit two-wait,
// 64-bit small memory) driven from one linear stimulus sequence with hand-computed expectations.
module tb_ahb3lite_dma_read_slave;
  import ahb3lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  HBURST_Type  hburst;
  HTRANS_state htrans;
  logic        hsel0, hsel2, hsel6;
  logic [15:0] cyc = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // dut0: 32-bit, zero wait, base 0x1000, 1024 words
  logic [31:0] d0_rdata, d0_mdata;
  logic        d0_ready, d0_en, d0_done;
  HRESP_state  d0_resp;
  logic [9:0]  d0_addr;

  // dut2: 32-bit, two wait states, base 0x1000, 1024 words
  logic [31:0] d2_rdata, d2_mdata;
  logic        d2_ready, d2_en, d2_done;
  HRESP_state  d2_resp;
  logic [9:0]  d2_addr;

  // dut6: 64-bit, zero wait, base 0x100, 16 words
  logic [63:0] d6_rdata, d6_mdata;
  logic        d6_ready, d6_en, d6_done;
  HRESP_state  d6_resp;
  logic [3:0]  d6_addr;

  ahb3lite_dma_read_slave #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h1000),
                            .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(d0_ready),
    .HRDATA(d0_rdata), .HREADYOUT(d0_ready), .HRESP(d0_resp), .mem_rd_en(d0_en),
    .mem_rd_addr(d0_addr), .mem_rd_data(d0_mdata), .slave_done(d0_done));

  ahb3lite_dma_read_slave #(.DATA_W(32), .ADDR_W(32), .BASE_ADDR(32'h1000),
                            .MEM_DEPTH(1024), .WAIT_STATES(2)) dut2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel2), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(d2_ready),
    .HRDATA(d2_rdata), .HREADYOUT(d2_ready), .HRESP(d2_resp), .mem_rd_en(d2_en),
    .mem_rd_addr(d2_addr), .mem_rd_data(d2_mdata), .slave_done(d2_done));

  ahb3lite_dma_read_slave #(.DATA_W(64), .ADDR_W(32), .BASE_ADDR(32'h100),
                            .MEM_DEPTH(16), .WAIT_STATES(0)) dut6 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel6), .HADDR(haddr), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(hburst), .HTRANS(htrans), .HREADY(d6_ready),
    .HRDATA(d6_rdata), .HREADYOUT(d6_ready), .HRESP(d6_resp), .mem_rd_en(d6_en),
    .mem_rd_addr(d6_addr), .mem_rd_data(d6_mdata), .slave_done(d6_done));

  // Memory models: word n reads as A5A5_<n>; without a read strobe the port shows junk.
  always @(posedge clk) begin
    d0_mdata <= d0_en ? (32'hA5A5_0000 | 32'(d0_addr)) : {16'hDEAD, cyc};
    d2_mdata <= d2_en ? (32'hA5A5_0000 | 32'(d2_addr)) : {16'hBEEF, cyc};
    d6_mdata <= d6_en ? {32'h6464_0000 | 32'(d6_addr), 32'hA5A5_0000 | 32'(d6_addr)}
                      : {32'hDEAD_0000, 16'h0, cyc};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic rdy, input HRESP_state resp, input logic done);
    check({tag, "_rdy"},  64'(d0_ready), 64'(rdy));
    check({tag, "_resp"}, 64'(d0_resp),  64'(resp));
    check({tag, "_done"}, 64'(d0_done),  64'(done));
  endtask

  task automatic chk2(input string tag, input logic rdy, input HRESP_state resp, input logic done);
    check({tag, "_rdy"},  64'(d2_ready), 64'(rdy));
    check({tag, "_resp"}, 64'(d2_resp),  64'(resp));
    check({tag, "_done"}, 64'(d2_done),  64'(done));
  endtask

  task automatic chk6(input string tag, input logic rdy, input HRESP_state resp, input logic done);
    check({tag, "_rdy"},  64'(d6_ready), 64'(rdy));
    check({tag, "_resp"}, 64'(d6_resp),  64'(resp));
    check({tag, "_done"}, 64'(d6_done),  64'(done));
  endtask

  // Drive one cycle's address-phase inputs at the falling edge, then let outputs settle.
  task automatic drv(input logic s0, input logic s2, input logic s6, input logic [31:0] a,
                     input HTRANS_state t, input HBURST_Type b, input logic w,
                     input logic [2:0] sz);
    @(negedge clk);
    hsel0 = s0; hsel2 = s2; hsel6 = s6;
    haddr = a; htrans = t; hburst = b; hwrite = w; hsize = sz;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 32'h0, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 3'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: a valid-looking request must not strobe memory while reset is low
    rst_n = 1'b0;
    drv(1'b1, 1'b0, 1'b0, 32'h1008, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd2);
    check("rst_en_gated", 64'(d0_en), 64'd0);
    drv(1'b1, 1'b0, 1'b0, 32'h1008, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd2);
    check("rst_en_gated2", 64'(d0_en), 64'd0);
    idle();
    rst_n = 1'b1;
    chk0("rst_d0", 1'b1, HRESP_OKAY, 1'b0);
    check("rst_d0_rdata", 64'(d0_rdata), 64'd0);
    chk2("rst_d2", 1'b1, HRESP_OKAY, 1'b0);
    chk6("rst_d6", 1'b1, HRESP_OKAY, 1'b0);

    // SINGLE read at BASE+8, zero wait
    drv(1'b1, 1'b0, 1'b0, 32'h1008, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd2);
    check("t1_en", 64'(d0_en), 64'd1);
    check("t1_addr", 64'(d0_addr), 64'd2);
    idle();
    check("t1_data", 64'(d0_rdata), 64'hA5A5_0002);
    chk0("t1_beat", 1'b1, HRESP_OKAY, 1'b0);
    idle();
    check("t1_done", 64'(d0_done), 64'd1);
    check("t1_rdata_idle", 64'(d0_rdata), 64'd0);
    idle();
    check("t1_done_clr", 64'(d0_done), 64'd0);

    // INCR4 from BASE with two wait states per beat
    drv(1'b0, 1'b1, 1'b0, 32'h1000, HTRANS_NONSEQ, HBURST_INCR4, 1'b0, 3'd2);
    check("t2_en0", 64'(d2_en), 64'd1);
    check("t2_addr0", 64'(d2_addr), 64'd0);
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 3; w++) begin
        if (k < 3)
          drv(1'b0, 1'b1, 1'b0, 32'h1000 + 32'(4 * (k + 1)), HTRANS_SEQ, HBURST_INCR4,
              1'b0, 3'd2);
        else
          drv(1'b0, 1'b1, 1'b0, 32'h0, HTRANS_IDLE, HBURST_INCR4, 1'b0, 3'd2);
        check($sformatf("t2_b%0d_w%0d_data", k, w), 64'(d2_rdata),
              64'(32'hA5A5_0000 | 32'(k)));
        chk2($sformatf("t2_b%0d_w%0d", k, w), (w == 2), HRESP_OKAY, 1'b0);
        check($sformatf("t2_b%0d_w%0d_en", k, w), 64'(d2_en), 64'(w == 2 && k < 3));
        if (w == 2 && k < 3)
          check($sformatf("t2_addr%0d", k + 1), 64'(d2_addr), 64'(k + 1));
      end
    end
    idle();
    check("t2_done", 64'(d2_done), 64'd1);
    idle();
    check("t2_done_clr", 64'(d2_done), 64'd0);

    // INCR of five beats with a BUSY after beat 2, terminated by IDLE
    drv(1'b1, 1'b0, 1'b0, 32'h1040, HTRANS_NONSEQ, HBURST_INCR, 1'b0, 3'd2);
    check("t3_addr16", 64'(d0_addr), 64'd16);
    drv(1'b1, 1'b0, 1'b0, 32'h1044, HTRANS_SEQ, HBURST_INCR, 1'b0, 3'd2);
    check("t3_b1_data", 64'(d0_rdata), 64'hA5A5_0010);
    check("t3_addr17", 64'(d0_addr), 64'd17);
    drv(1'b1, 1'b0, 1'b0, 32'h1048, HTRANS_BUSY, HBURST_INCR, 1'b0, 3'd2);
    check("t3_b2_data", 64'(d0_rdata), 64'hA5A5_0011);
    check("t3_busy_en", 64'(d0_en), 64'd0);
    drv(1'b1, 1'b0, 1'b0, 32'h1048, HTRANS_SEQ, HBURST_INCR, 1'b0, 3'd2);
    chk0("t3_busy_resp", 1'b1, HRESP_OKAY, 1'b0);
    check("t3_busy_rdata", 64'(d0_rdata), 64'd0);
    check("t3_addr18", 64'(d0_addr), 64'd18);
    drv(1'b1, 1'b0, 1'b0, 32'h104C, HTRANS_SEQ, HBURST_INCR, 1'b0, 3'd2);
    check("t3_b3_data", 64'(d0_rdata), 64'hA5A5_0012);
    check("t3_b3_done", 64'(d0_done), 64'd0);
    drv(1'b1, 1'b0, 1'b0, 32'h1050, HTRANS_SEQ, HBURST_INCR, 1'b0, 3'd2);
    check("t3_b4_data", 64'(d0_rdata), 64'hA5A5_0013);
    check("t3_addr20", 64'(d0_addr), 64'd20);
    drv(1'b1, 1'b0, 1'b0, 32'h1054, HTRANS_IDLE, HBURST_INCR, 1'b0, 3'd2);
    check("t3_b5_data", 64'(d0_rdata), 64'hA5A5_0014);
    chk0("t3_b5", 1'b1, HRESP_OKAY, 1'b0);
    idle();
    check("t3_done", 64'(d0_done), 64'd1);
    idle();
    check("t3_done_clr", 64'(d0_done), 64'd0);

    // Out of range, write, oversize: each a two-cycle ERROR, no strobe, no done
    drv(1'b1, 1'b0, 1'b0, 32'h2000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd2);
    check("t4_oor_en", 64'(d0_en), 64'd0);
    idle();
    chk0("t4_oor_err1", 1'b0, HRESP_ERROR, 1'b0);
    check("t4_err_rdata", 64'(d0_rdata), 64'd0);
    drv(1'b1, 1'b0, 1'b0, 32'h1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 3'd2);
    chk0("t4_oor_err2", 1'b1, HRESP_ERROR, 1'b0);
    check("t4_wr_en", 64'(d0_en), 64'd0);
    idle();
    chk0("t4_wr_err1", 1'b0, HRESP_ERROR, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 32'h1000, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd3);
    chk0("t4_wr_err2", 1'b1, HRESP_ERROR, 1'b0);
    check("t4_sz_en", 64'(d0_en), 64'd0);
    idle();
    chk0("t4_sz_err1", 1'b0, HRESP_ERROR, 1'b0);
    idle();
    chk0("t4_sz_err2", 1'b1, HRESP_ERROR, 1'b0);
    drv(1'b1, 1'b0, 1'b0, 32'h1FFC, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd2);
    chk0("t4_after_err", 1'b1, HRESP_OKAY, 1'b0);
    check("t4_last_en", 64'(d0_en), 64'd1);
    check("t4_last_addr", 64'(d0_addr), 64'd1023);
    idle();
    check("t4_last_data", 64'(d0_rdata), 64'hA5A5_03FF);
    idle();
    check("t4_last_done", 64'(d0_done), 64'd1);

    // Reset during the second wait cycle of an INCR8 beat
    drv(1'b0, 1'b1, 1'b0, 32'h1000, HTRANS_NONSEQ, HBURST_INCR8, 1'b0, 3'd2);
    check("t5_en", 64'(d2_en), 64'd1);
    drv(1'b0, 1'b1, 1'b0, 32'h1004, HTRANS_SEQ, HBURST_INCR8, 1'b0, 3'd2);
    check("t5_w1_rdy", 64'(d2_ready), 64'd0);
    drv(1'b0, 1'b1, 1'b0, 32'h1004, HTRANS_SEQ, HBURST_INCR8, 1'b0, 3'd2);
    rst_n = 1'b0;
    #1;
    check("t5_w2_rdy", 64'(d2_ready), 64'd0);
    idle();
    rst_n = 1'b1;
    chk2("t5_post_rst", 1'b1, HRESP_OKAY, 1'b0);
    check("t5_post_rst_rdata", 64'(d2_rdata), 64'd0);
    idle();
    check("t5_no_done", 64'(d2_done), 64'd0);
    drv(1'b0, 1'b1, 1'b0, 32'h1008, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd2);
    check("t5_new_en", 64'(d2_en), 64'd1);
    check("t5_new_addr", 64'(d2_addr), 64'd2);
    idle();
    chk2("t5_new_w1", 1'b0, HRESP_OKAY, 1'b0);
    check("t5_new_w1_data", 64'(d2_rdata), 64'hA5A5_0002);
    idle();
    check("t5_new_w2_data", 64'(d2_rdata), 64'hA5A5_0002);
    idle();
    chk2("t5_new_end", 1'b1, HRESP_OKAY, 1'b0);
    check("t5_new_end_data", 64'(d2_rdata), 64'hA5A5_0002);
    idle();
    check("t5_new_done", 64'(d2_done), 64'd1);

    // 64-bit slave at base 0x100, 16 words
    drv(1'b0, 1'b0, 1'b1, 32'h138, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd3);
    check("t6_en", 64'(d6_en), 64'd1);
    check("t6_addr", 64'(d6_addr), 64'd7);
    idle();
    check("t6_data", d6_rdata, 64'h6464_0007_A5A5_0007);
    chk6("t6_beat", 1'b1, HRESP_OKAY, 1'b0);
    idle();
    check("t6_done", 64'(d6_done), 64'd1);
    drv(1'b0, 1'b0, 1'b1, 32'h180, HTRANS_NONSEQ, HBURST_SINGLE, 1'b0, 3'd3);
    check("t6_oor_en", 64'(d6_en), 64'd0);
    idle();
    chk6("t6_err1", 1'b0, HRESP_ERROR, 1'b0);
    idle();
    chk6("t6_err2", 1'b1, HRESP_ERROR, 1'b0);
    idle();
    chk6("t6_idle", 1'b1, HRESP_OKAY, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
